// File: rtl/adc_acquisition_scheduler.sv
// Paces ADC conversions, accumulates 2^ACC_LOG2 signed samples per frame, and recovers the ADC on error or timeout.
// Samples are reported one cycle after the data_enable edge; there is no backpressure, and late period ticks are dropped and counted.
module adc_acquisition_scheduler #(
  parameter int ACC_LOG2         = 4,
  parameter int ADC_RESET_CYCLES = 4,
  parameter int SETTLE_CYCLES    = 2048,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [31:0]           period,
  output logic                  adc_start,
  output logic                  adc_reset,
  input  logic                  adc_data_enable,
  input  logic                  adc_is_error,
  input  logic [15:0]           adc_data,
  output logic [15:0]           sample_out,
  output logic                  sample_valid,
  output logic [16+ACC_LOG2-1:0] frame_sum,
  output logic                  frame_valid,
  output logic [15:0]           frame_count,
  output logic [7:0]            error_count,
  output logic [7:0]            overrun_count,
  output logic                  busy
);

  localparam int ACC_W   = 16 + ACC_LOG2;
  localparam int IDX_W   = (ACC_LOG2 > 0) ? ACC_LOG2 : 1;
  localparam int CYC_MAX = (SETTLE_CYCLES > ADC_RESET_CYCLES) ? SETTLE_CYCLES : ADC_RESET_CYCLES;
  localparam int CYC_W   = $clog2(CYC_MAX) + 1;
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << ACC_LOG2) - 1);

  typedef enum logic [2:0] {
    S_RESET_ADC,
    S_SETTLE,
    S_IDLE,
    S_ARMED,
    S_WAIT_DATA,
    S_WAIT_RELEASE,
    S_RECOVER
  } state_t;

  state_t             state_q, state_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [31:0]        period_q, period_d;
  logic [31:0]        pcnt_q, pcnt_d;
  logic [TO_W-1:0]    tcnt_q, tcnt_d;
  logic               de_prev_q, de_prev_d;
  logic               start_q, start_d;
  logic [15:0]        sample_q, sample_d;
  logic               sample_vld_q, sample_vld_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ACC_W-1:0]   frame_sum_q, frame_sum_d;
  logic               frame_vld_q, frame_vld_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic [7:0]         err_cnt_q, err_cnt_d;
  logic [7:0]         ovr_cnt_q, ovr_cnt_d;

  logic               running;
  logic               tick;
  logic               de_rise;
  logic               err_hit;
  logic [ACC_W-1:0]   acc_sum;

  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    period_d     = period_q;
    pcnt_d       = pcnt_q;
    tcnt_d       = tcnt_q;
    de_prev_d    = adc_data_enable;
    start_d      = 1'b0;
    sample_d     = sample_q;
    sample_vld_d = 1'b0;
    acc_d        = acc_q;
    idx_d        = idx_q;
    frame_sum_d  = frame_sum_q;
    frame_vld_d  = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    err_cnt_d    = err_cnt_q;
    ovr_cnt_d    = ovr_cnt_q;

    running = (state_q == S_ARMED) || (state_q == S_WAIT_DATA) || (state_q == S_WAIT_RELEASE);
    tick    = running && (pcnt_q == period_q - 32'd1);
    de_rise = adc_data_enable && !de_prev_q;
    err_hit = running && adc_is_error;
    acc_sum = acc_q + ACC_W'(signed'(adc_data));

    if (running) begin
      pcnt_d = tick ? 32'd0 : pcnt_q + 32'd1;
    end
    // A tick while a conversion is still in flight cannot start a new one.
    if (tick && (state_q != S_ARMED) && (ovr_cnt_q != 8'hFF)) begin
      ovr_cnt_d = ovr_cnt_q + 8'd1;
    end

    case (state_q)
      S_RESET_ADC: begin
        if (cyc_q == CYC_W'(ADC_RESET_CYCLES - 1)) begin
          cyc_d   = '0;
          state_d = S_SETTLE;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_SETTLE: begin
        if (cyc_q == CYC_W'(SETTLE_CYCLES - 1)) begin
          cyc_d   = '0;
          state_d = S_IDLE;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_IDLE: begin
        period_d = (period == 32'd0) ? 32'd1 : period;
        pcnt_d   = '0;
        acc_d    = '0;
        idx_d    = '0;
        if (enable) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (err_hit) begin
          state_d = S_RECOVER;
        end else if (!enable) begin
          state_d = S_IDLE;
        end else if (tick) begin
          start_d = 1'b1;
          tcnt_d  = '0;
          state_d = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        if (err_hit) begin
          state_d = S_RECOVER;
        end else if (de_rise) begin
          sample_d     = adc_data;
          sample_vld_d = 1'b1;
          state_d      = S_WAIT_RELEASE;
          if (idx_q == IDX_LAST) begin
            frame_sum_d = acc_sum;
            frame_vld_d = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
            acc_d       = '0;
            idx_d       = '0;
          end else begin
            acc_d = acc_sum;
            idx_d = idx_q + 1'b1;
          end
        end else if (tcnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_RECOVER;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_WAIT_RELEASE: begin
        if (err_hit) begin
          state_d = S_RECOVER;
        end else if (!adc_data_enable) begin
          state_d = S_ARMED;
        end
      end
      S_RECOVER: begin
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        acc_d   = '0;
        idx_d   = '0;
        cyc_d   = '0;
        state_d = S_RESET_ADC;
      end
      default: begin
        cyc_d   = '0;
        state_d = S_RESET_ADC;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_RESET_ADC;
      cyc_q        <= '0;
      period_q     <= 32'd1;
      pcnt_q       <= '0;
      tcnt_q       <= '0;
      de_prev_q    <= 1'b0;
      start_q      <= 1'b0;
      sample_q     <= '0;
      sample_vld_q <= 1'b0;
      acc_q        <= '0;
      idx_q        <= '0;
      frame_sum_q  <= '0;
      frame_vld_q  <= 1'b0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
      ovr_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      period_q     <= period_d;
      pcnt_q       <= pcnt_d;
      tcnt_q       <= tcnt_d;
      de_prev_q    <= de_prev_d;
      start_q      <= start_d;
      sample_q     <= sample_d;
      sample_vld_q <= sample_vld_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      frame_sum_q  <= frame_sum_d;
      frame_vld_q  <= frame_vld_d;
      frame_cnt_q  <= frame_cnt_d;
      err_cnt_q    <= err_cnt_d;
      ovr_cnt_q    <= ovr_cnt_d;
    end
  end

  assign adc_start     = start_q;
  assign adc_reset     = (state_q == S_RESET_ADC);
  assign busy          = (state_q != S_IDLE);
  assign sample_out    = sample_q;
  assign sample_valid  = sample_vld_q;
  assign frame_sum     = frame_sum_q;
  assign frame_valid   = frame_vld_q;
  assign frame_count   = frame_cnt_q;
  assign error_count   = err_cnt_q;
  assign overrun_count = ovr_cnt_q;

endmodule

// File: tb/tb_adc_acquisition_scheduler.sv
// Directed bench for adc_acquisition_scheduler with a behavioural ADC controller model.
// Inputs change and outputs are sampled 1ns after the falling clock edge.
module tb_adc_acquisition_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] period;
  logic        adc_start;
  logic        adc_reset;
  logic        adc_data_enable = 1'b0;
  logic        adc_is_error;
  logic [15:0] adc_data = 16'h0000;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic [19:0] frame_sum;
  logic        frame_valid;
  logic [15:0] frame_count;
  logic [7:0]  error_count;
  logic [7:0]  overrun_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adc_acquisition_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .period          (period),
    .adc_start       (adc_start),
    .adc_reset       (adc_reset),
    .adc_data_enable (adc_data_enable),
    .adc_is_error    (adc_is_error),
    .adc_data        (adc_data),
    .sample_out      (sample_out),
    .sample_valid    (sample_valid),
    .frame_sum       (frame_sum),
    .frame_valid     (frame_valid),
    .frame_count     (frame_count),
    .error_count     (error_count),
    .overrun_count   (overrun_count),
    .busy            (busy)
  );

  // ADC controller model: data_enable rises lat cycles after a start and stays high for hold cycles.
  bit          model_en = 1'b1;
  int          lat = 150;
  int          hold = 20;
  logic [15:0] tbl [0:127];
  int          model_idx = 0;

  always begin
    @(negedge clk);
    if (adc_start === 1'b1 && model_en) begin
      adc_data  = tbl[model_idx[6:0]];
      model_idx = model_idx + 1;
      repeat (lat) @(negedge clk);
      adc_data_enable = 1'b1;
      repeat (hold) @(negedge clk);
      adc_data_enable = 1'b0;
    end
  end

  int          cyc = 0;
  int          sv_cnt = 0;
  int          fv_cnt = 0;
  int          fv_alone = 0;
  int          st_cyc[$];
  logic [19:0] last_fsum = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sample_valid === 1'b1) sv_cnt = sv_cnt + 1;
    if (frame_valid === 1'b1) begin
      fv_cnt    = fv_cnt + 1;
      last_fsum = frame_sum;
      if (sample_valid !== 1'b1) fv_alone = fv_alone + 1;
    end
    if (adc_start === 1'b1) st_cyc.push_back(cyc);
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish by %0t", $time);
    $fatal(1);
  end

  task automatic step(input int k);
    repeat (k) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_sv(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step(1);
      if (sv_cnt >= target) ok = 1'b1;
    end
  endtask

  task automatic wait_start(input int budget, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < budget) begin
      step(1);
      n++;
      if (adc_start === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    int n;
    reset = 1'b1; enable = 1'b0; adc_is_error = 1'b0; model_en = 1'b1;
    lat = 150; hold = 20;
    step(3);
    reset = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 2200) begin
      step(1);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_to_idle busy=%b after %0d cycles, want 0", busy, n);
    end
  endtask

  task automatic interval_bad(input int from, input int want, output int bad);
    bad = 0;
    for (int i = from + 1; i < st_cyc.size(); i++)
      if (st_cyc[i] - st_cyc[i-1] != want) bad++;
  endtask

  task automatic test_reset();
    int n_rst, n_idle;
    reset = 1'b1; enable = 1'b0; period = 32'd200; adc_is_error = 1'b0;
    step(3);
    checks++;
    if ({adc_reset, busy, adc_start} !== 3'b110) begin
      errors++;
      $display("FAIL reset_ctrl {adc_reset,busy,adc_start}=%b want 110", {adc_reset, busy, adc_start});
    end
    checks++;
    if ({sample_out, sample_valid, frame_sum, frame_valid} !== '0) begin
      errors++;
      $display("FAIL reset_data sample_out=%h sv=%b frame_sum=%h fv=%b want 0", sample_out, sample_valid, frame_sum, frame_valid);
    end
    checks++;
    if ({frame_count, error_count, overrun_count} !== '0) begin
      errors++;
      $display("FAIL reset_counts fc=%0d ec=%0d oc=%0d want 0", frame_count, error_count, overrun_count);
    end
    reset = 1'b0;
    n_rst = 0; n_idle = 0;
    while (busy === 1'b1 && n_idle < 3000) begin
      if (adc_reset === 1'b1) n_rst++;
      step(1);
      n_idle++;
    end
    checks++;
    if (n_rst != 4) begin
      errors++;
      $display("FAIL reset_adc_len adc_reset high %0d cycles, want 4", n_rst);
    end
    checks++;
    if (n_idle != 2052) begin
      errors++;
      $display("FAIL reset_idle_time idle after %0d cycles, want 2052", n_idle);
    end
  endtask

  task automatic test_nominal();
    int sv0, fv0, st0, n, bad;
    bit ok;
    do_reset();
    for (int i = 0; i < 16; i++) tbl[(model_idx + i) % 128] = 16'h0010;
    sv0 = sv_cnt; fv0 = fv_cnt; st0 = st_cyc.size();
    period = 32'd200;
    enable = 1'b1;
    wait_start(400, n, ok);
    checks++;
    if (!ok || n != 201) begin
      errors++;
      $display("FAIL nominal_first_start start after %0d cycles (seen=%b), want 201", n, ok);
    end
    wait_sv(sv0 + 16, 4000, ok);
    enable = 1'b0;
    step(100);
    checks++;
    if (!ok || sv_cnt - sv0 != 16) begin
      errors++;
      $display("FAIL nominal_samples got %0d samples, want 16", sv_cnt - sv0);
    end
    checks++;
    if (fv_cnt - fv0 != 1 || fv_alone != 0) begin
      errors++;
      $display("FAIL nominal_frames frames=%0d unaligned=%0d, want 1 and 0", fv_cnt - fv0, fv_alone);
    end
    checks++;
    if (last_fsum !== 20'h00100 || frame_sum !== 20'h00100) begin
      errors++;
      $display("FAIL nominal_sum pulse=%h held=%h want 00100", last_fsum, frame_sum);
    end
    checks++;
    if (frame_count !== 16'd1 || sample_out !== 16'h0010) begin
      errors++;
      $display("FAIL nominal_count fc=%0d sample_out=%h want 1 and 0010", frame_count, sample_out);
    end
    interval_bad(st0, 200, bad);
    checks++;
    if (st_cyc.size() - st0 != 16 || bad != 0) begin
      errors++;
      $display("FAIL nominal_starts starts=%0d bad_intervals=%0d, want 16 and 0", st_cyc.size() - st0, bad);
    end
    checks++;
    if ({overrun_count, error_count, busy} !== 17'd0) begin
      errors++;
      $display("FAIL nominal_idle oc=%0d ec=%0d busy=%b want 0", overrun_count, error_count, busy);
    end
  endtask

  task automatic test_signed_sum();
    int sv0;
    bit ok;
    do_reset();
    for (int i = 0; i < 16; i++) tbl[(model_idx + i) % 128] = i[0] ? 16'h8000 : 16'h7FFF;
    sv0 = sv_cnt;
    period = 32'd200;
    enable = 1'b1;
    wait_sv(sv0 + 16, 4000, ok);
    enable = 1'b0;
    step(100);
    checks++;
    if (!ok || frame_sum !== 20'hFFFF8) begin
      errors++;
      $display("FAIL signed_sum frame_sum=%h want FFFF8", frame_sum);
    end
    checks++;
    if (frame_count !== 16'd1 || sample_out !== 16'h8000) begin
      errors++;
      $display("FAIL signed_last fc=%0d sample_out=%h want 1 and 8000", frame_count, sample_out);
    end
  endtask

  task automatic test_overrun();
    int sv0, st0, n, bad;
    bit ok;
    do_reset();
    for (int i = 0; i < 4; i++) tbl[(model_idx + i) % 128] = 16'h0003;
    sv0 = sv_cnt; st0 = st_cyc.size();
    period = 32'd50;
    enable = 1'b1;
    wait_start(200, n, ok);
    checks++;
    if (!ok || n != 51) begin
      errors++;
      $display("FAIL overrun_first_start start after %0d cycles, want 51", n);
    end
    wait_sv(sv0 + 4, 1500, ok);
    enable = 1'b0;
    step(60);
    checks++;
    if (!ok || overrun_count !== 8'd12) begin
      errors++;
      $display("FAIL overrun_count got %0d want 12", overrun_count);
    end
    interval_bad(st0, 200, bad);
    checks++;
    if (st_cyc.size() - st0 != 4 || sv_cnt - sv0 != 4 || bad != 0) begin
      errors++;
      $display("FAIL overrun_starts starts=%0d samples=%0d bad=%0d want 4 4 0", st_cyc.size() - st0, sv_cnt - sv0, bad);
    end
  endtask

  task automatic test_period_zero();
    int sv0, st0, n, bad;
    bit ok;
    do_reset();
    for (int i = 0; i < 2; i++) tbl[(model_idx + i) % 128] = 16'h0001;
    sv0 = sv_cnt; st0 = st_cyc.size();
    period = 32'd0;
    enable = 1'b1;
    wait_start(20, n, ok);
    checks++;
    if (!ok || n != 2) begin
      errors++;
      $display("FAIL period0_first_start start after %0d cycles, want 2", n);
    end
    wait_sv(sv0 + 2, 800, ok);
    enable = 1'b0;
    step(200);
    checks++;
    if (!ok || overrun_count !== 8'd255) begin
      errors++;
      $display("FAIL period0_saturate overrun=%0d want 255", overrun_count);
    end
    interval_bad(st0, 172, bad);
    checks++;
    if (st_cyc.size() - st0 != 2 || bad != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL period0_starts starts=%0d bad=%0d busy=%b want 2 0 0", st_cyc.size() - st0, bad, busy);
    end
  endtask

  task automatic test_error_midframe();
    int sv0, fv0, n;
    bit ok;
    do_reset();
    for (int i = 0; i < 5; i++) tbl[(model_idx + i) % 128] = 16'h1000;
    for (int i = 0; i < 16; i++) tbl[(model_idx + 5 + i) % 128] = 16'(i + 1);
    sv0 = sv_cnt; fv0 = fv_cnt;
    period = 32'd200;
    enable = 1'b1;
    wait_sv(sv0 + 5, 1500, ok);
    adc_is_error = 1'b1;
    step(1);
    adc_is_error = 1'b0;
    n = 0;
    while (adc_reset !== 1'b1 && n < 10) begin
      step(1);
      n++;
    end
    checks++;
    if (!ok || error_count !== 8'd1) begin
      errors++;
      $display("FAIL error_count got %0d want 1", error_count);
    end
    n = 0;
    while (adc_reset === 1'b1 && n < 20) begin
      n++;
      step(1);
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL error_adc_reset high %0d cycles want 4", n);
    end
    wait_sv(sv0 + 21, 7000, ok);
    enable = 1'b0;
    step(100);
    checks++;
    if (!ok || fv_cnt - fv0 != 1 || last_fsum !== 20'h00088) begin
      errors++;
      $display("FAIL error_refill frames=%0d sum=%h want 1 and 00088", fv_cnt - fv0, last_fsum);
    end
    checks++;
    if (frame_count !== 16'd1 || sv_cnt - sv0 != 21) begin
      errors++;
      $display("FAIL error_totals fc=%0d samples=%0d want 1 and 21", frame_count, sv_cnt - sv0);
    end
  endtask

  task automatic test_timeout_and_reset();
    int n;
    bit ok;
    do_reset();
    model_en = 1'b0;
    period = 32'd200;
    enable = 1'b1;
    wait_start(400, n, ok);
    n = 0;
    while (adc_reset !== 1'b1 && n < 1200) begin
      step(1);
      n++;
    end
    checks++;
    if (!ok || n != 1025) begin
      errors++;
      $display("FAIL timeout_latency adc_reset after %0d cycles, want 1025", n);
    end
    checks++;
    if (error_count !== 8'd1 || overrun_count !== 8'd5) begin
      errors++;
      $display("FAIL timeout_counts ec=%0d oc=%0d want 1 and 5", error_count, overrun_count);
    end
    wait_start(3000, n, ok);
    step(10);
    reset = 1'b1;
    #1;
    checks++;
    if (!ok || {adc_reset, busy, adc_start} !== 3'b110) begin
      errors++;
      $display("FAIL async_reset_ctrl {adc_reset,busy,adc_start}=%b want 110", {adc_reset, busy, adc_start});
    end
    checks++;
    if ({frame_count, error_count, overrun_count} !== '0) begin
      errors++;
      $display("FAIL async_reset_counts fc=%0d ec=%0d oc=%0d want 0", frame_count, error_count, overrun_count);
    end
    enable = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    period = 32'd200;
    adc_is_error = 1'b0;
    test_reset();
    test_nominal();
    test_signed_sum();
    test_overrun();
    test_period_zero();
    test_error_midframe();
    test_timeout_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
